// File: rtl/kernel_window_scheduler_if.sv
// rtl/kernel_window_scheduler_if.sv - pixel-in / window-out bundle for kernel_window_scheduler
// Purpose: groups the raster input stream and the window/sideband outputs.
// Signals:
//   pix_in, pix_valid, sof             raster pixel stream (no backpressure)
//   buffer_3                           3x3 window [r][c], r=0 oldest row, c=0 oldest column
//   win_valid                          buffer_3 holds a full interior window
//   out_valid, out_x, out_y            sideband aligned with the kernel's registered output
//   frame_done, frame_err              single-cycle frame status pulses
// Modports: master = pixel source / observer, slave = scheduler.
interface kernel_window_scheduler_if #(
    parameter int PRECISION = 16,
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic signed [PRECISION-1:0]           pix_in;
    logic                                  pix_valid;
    logic                                  sof;
    logic signed [2:0][2:0][PRECISION-1:0] buffer_3;
    logic                                  win_valid;
    logic                                  out_valid;
    logic [XW-1:0]                         out_x;
    logic [YW-1:0]                         out_y;
    logic                                  frame_done;
    logic                                  frame_err;

    modport master (
        output pix_in, pix_valid, sof,
        input  buffer_3, win_valid, out_valid, out_x, out_y, frame_done, frame_err
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output buffer_3, win_valid, out_valid, out_x, out_y, frame_done, frame_err
    );
endinterface

// File: rtl/kernel_window_scheduler.sv
// rtl/kernel_window_scheduler.sv - raster to 3x3 window scheduler with aligned valid/coordinate sideband
// Purpose: keeps two line buffers and a 3x3 shift window fed from a raster pixel
//   stream, flags interior windows, and delays {valid, centre x, centre y} by
//   KERNEL_LATENCY so they line up with a free-running kernel's output.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    kernel_window_scheduler_if.slave (pixel stream in, window and sideband out)
module kernel_window_scheduler #(
    parameter int PRECISION      = 16,
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int KERNEL_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    kernel_window_scheduler_if.slave     bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [XW-1:0]                   col_q;
    logic [YW-1:0]                   row_q;
    logic [XW-1:0]                   px;
    logic [YW-1:0]                   py;
    logic                            accept;
    logic                            restart;
    logic                            last;

    logic [PRECISION-1:0]            lb0 [WIDTH];
    logic [PRECISION-1:0]            lb1 [WIDTH];
    logic [2:0][2:0][PRECISION-1:0]  win_q;
    logic                            win_valid_q;
    logic [XW-1:0]                   cx_q;
    logic [YW-1:0]                   cy_q;
    logic                            err_q;

    logic                            dl_v [KERNEL_LATENCY];
    logic [XW-1:0]                   dl_x [KERNEL_LATENCY];
    logic [YW-1:0]                   dl_y [KERNEL_LATENCY];

    // Decide whether this cycle's pixel is taken and at which position.
    // A pixel carrying sof always lands at (0,0), whatever the counters say.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        restart = 1'b0;
        px      = col_q;
        py      = row_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.pix_valid && bus.sof) begin
                    accept = 1'b1;
                    px     = '0;
                    py     = '0;
                end
            end
            RUN: begin
                if (bus.pix_valid) begin
                    accept = 1'b1;
                    if (bus.sof) begin
                        restart = 1'b1;
                        px      = '0;
                        py      = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last = accept && (px == X_LAST) && (py == Y_LAST);
        if (accept) begin
            state_d = last ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // Line buffers are plain storage without reset; stale contents never
    // reach an asserted win_valid because of the row >= 2 gating.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[px] <= lb0[px];
            lb0[px] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= restart;
            win_valid_q <= accept && (px >= X_TWO) && (py >= Y_TWO);
            if (accept) begin
                if (px == X_LAST) begin
                    col_q <= '0;
                    row_q <= (py == Y_LAST) ? '0 : py + 1'b1;
                end else begin
                    col_q <= px + 1'b1;
                    row_q <= py;
                end
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1[px];
                win_q[1][2] <= lb0[px];
                win_q[2][2] <= bus.pix_in;
                // Centre of the window just formed; only meaningful with win_valid.
                cx_q <= px - 1'b1;
                cy_q <= py - 1'b1;
            end
        end
    end

    // Sideband delay line shifts every cycle since the kernel never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KERNEL_LATENCY; i++) begin
                dl_v[i] <= 1'b0;
                dl_x[i] <= '0;
                dl_y[i] <= '0;
            end
        end else begin
            dl_v[0] <= win_valid_q;
            dl_x[0] <= cx_q;
            dl_y[0] <= cy_q;
            for (int i = 1; i < KERNEL_LATENCY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_x[i] <= dl_x[i-1];
                dl_y[i] <= dl_y[i-1];
            end
        end
    end

    assign bus.buffer_3   = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.out_valid  = dl_v[KERNEL_LATENCY-1];
    assign bus.out_x      = dl_x[KERNEL_LATENCY-1];
    assign bus.out_y      = dl_y[KERNEL_LATENCY-1];
    assign bus.frame_done = (state_q == DONE);
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_kernel_window_scheduler.sv
// tb/tb_kernel_window_scheduler.sv - self-checking bench for kernel_window_scheduler
module tb_kernel_window_scheduler;
    localparam int P = 16;
    localparam int W = 5;
    localparam int H = 4;
    localparam int L = 1;

    typedef struct {
        logic [2:0][2:0][P-1:0] win;
        int x;
        int y;
        int cyc;
    } exp_t;

    typedef struct {
        int gap;
        int junk;
        int abort;
        int frames;
        int exp_out;
        int exp_done;
        int exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out, n_done, n_err;
    exp_t wq[$];
    exp_t oq[$];
    exp_t me;
    vec_t tbl[5];

    kernel_window_scheduler_if #(.PRECISION(P), .WIDTH(W), .HEIGHT(H)) bus ();

    kernel_window_scheduler #(
        .PRECISION(P), .WIDTH(W), .HEIGHT(H), .KERNEL_LATENCY(L)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard side: windows are checked when win_valid fires, then the
    // coordinates move to the output queue to be checked at out_valid.
    always @(negedge clk) begin
        if (bus.win_valid) begin
            if (wq.size() == 0) begin
                check("win_unexpected", 1, 0);
            end else begin
                me = wq.pop_front();
                check("window", bus.buffer_3, me.win);
                check("win_latency", cyc - me.cyc, 1);
                me.cyc = cyc;
                oq.push_back(me);
            end
        end
        if (bus.out_valid) begin
            n_out++;
            if (oq.size() == 0) begin
                check("out_unexpected", 1, 0);
            end else begin
                me = oq.pop_front();
                check("out_x", bus.out_x, me.x);
                check("out_y", bus.out_y, me.y);
                check("out_latency", cyc - me.cyc, L);
            end
        end
        if (bus.frame_done) n_done++;
        if (bus.frame_err)  n_err++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_buffer_3"}, bus.buffer_3, 0);
        check({tag, "_win_valid"}, bus.win_valid, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_x"}, bus.out_x, 0);
        check({tag, "_out_y"}, bus.out_y, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    task automatic drive_pix(input int x, input int y, input int base, input bit s, input int gap);
        exp_t e;
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        bus.pix_in    = 16'(base + W * y + x);
        if (x >= 2 && y >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[r][c] = 16'(base + W * (y - 2 + r) + (x - 2 + c));
            e.x   = x - 1;
            e.y   = y - 1;
            e.cyc = cyc;
            wq.push_back(e);
        end
        step();
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        repeat (gap) step();
    endtask

    task automatic drive_frame(input int base, input int gap, input int stop);
        for (int p = 0; p < W * H; p++) begin
            if (stop >= 0 && p >= stop) break;
            drive_pix(p % W, p / W, base, p == 0, gap);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wq.delete();
        oq.delete();
        n_out  = 0;
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        repeat (v.junk) begin
            bus.pix_valid = 1'b1;
            bus.sof       = 1'b0;
            bus.pix_in    = 16'd99;
            step();
            bus.pix_valid = 1'b0;
        end
        if (v.abort >= 0) drive_frame(200, v.gap, v.abort);
        for (int f = 0; f < v.frames; f++) drive_frame(40 * f, v.gap, -1);
        repeat (4) step();
        check("out_count", n_out, v.exp_out);
        check("done_count", n_done, v.exp_done);
        check("err_count", n_err, v.exp_err);
        check("win_pending", wq.size(), 0);
        check("out_pending", oq.size(), 0);
    endtask

    initial begin
        n_out = 0; n_done = 0; n_err = 0;
        reset         = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;

        //        gap junk abort frames outs done err
        tbl[0] = '{0, 0, -1, 1, 6,  1, 0};
        tbl[1] = '{1, 0, -1, 1, 6,  1, 0};
        tbl[2] = '{0, 2, -1, 1, 6,  1, 0};
        tbl[3] = '{0, 0,  8, 1, 6,  1, 1};
        tbl[4] = '{0, 0, -1, 2, 12, 2, 0};
        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reset after pixel 13: outputs clear on the next edge, nothing in flight survives.
        do_reset();
        drive_frame(0, 0, 14);
        reset = 1'b1;
        step();
        check_zero("midreset");
        reset = 1'b0;
        wq.delete();
        oq.delete();
        n_out = 0;
        repeat (6) step();
        check("midreset_no_out", n_out, 0);

        run_vec(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
